// File: rtl/boot_copy_ahb.sv
// rtl/boot_copy_ahb.sv - AHB-Lite master copying WORDS boot ROM words into RAM.
module boot_copy_ahb #(
    parameter int          PA_BITS  = 32,
    parameter int          XLEN     = 64,
    parameter logic [63:0] SRC_BASE = 64'h1000,
    parameter logic [63:0] DST_BASE = 64'h8000_0000,
    parameter int          WORDS    = 1024
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               Start,
    output logic               Busy,
    output logic               Done,
    output logic               Error,
    output logic [PA_BITS-1:0] HADDR,
    output logic               HWRITE,
    output logic [1:0]         HTRANS,
    output logic [2:0]         HSIZE,
    output logic [2:0]         HBURST,
    output logic [XLEN-1:0]    HWDATA,
    input  logic [XLEN-1:0]    HRDATA,
    input  logic               HREADY,
    input  logic               HRESP
);
    localparam int CW    = (WORDS > 0) ? $clog2(WORDS + 1) : 1;
    localparam int SHIFT = $clog2(XLEN / 8);
    localparam logic [CW:0] NWORDS = (CW + 1)'(WORDS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ADDR = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR_ADDR = 3'd3;
    localparam logic [2:0] S_WR_DATA = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] d_q, d_d;
    logic [CW:0]     cnt_inc;
    logic            more;

    function automatic logic [PA_BITS-1:0] word_addr(input logic [63:0] base, input logic [CW:0] idx);
        return PA_BITS'(base) + (PA_BITS'(idx) << SHIFT);
    endfunction

    assign cnt_inc = {1'b0, cnt_q} + (CW + 1)'(1);
    assign more    = cnt_inc < NWORDS;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        HTRANS  = T_IDLE;
        HWRITE  = 1'b0;
        HADDR   = word_addr(SRC_BASE, {1'b0, cnt_q});
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (Start) begin
                    cnt_d   = '0;
                    state_d = (WORDS == 0) ? S_DONE : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                HTRANS = T_NONSEQ;
                if (HREADY) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (HREADY) begin
                    if (HRESP) begin
                        state_d = S_ERROR;
                    end else begin
                        d_d     = HRDATA;
                        state_d = S_WR_ADDR;
                    end
                end
            end
            S_WR_ADDR: begin
                HTRANS = T_NONSEQ;
                HWRITE = 1'b1;
                HADDR  = word_addr(DST_BASE, {1'b0, cnt_q});
                if (HREADY) state_d = S_WR_DATA;
            end
            S_WR_DATA: begin
                // The next read address rides on this write data phase; an error response cancels it.
                if (more && !HRESP) begin
                    HTRANS = T_NONSEQ;
                    HADDR  = word_addr(SRC_BASE, cnt_inc);
                end
                if (HREADY) begin
                    if (HRESP) begin
                        state_d = S_ERROR;
                    end else begin
                        cnt_d   = cnt_inc[CW-1:0];
                        state_d = more ? S_RD_DATA : S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
        end
    end

    assign Busy   = (state_q >= S_RD_ADDR) && (state_q <= S_WR_DATA);
    assign Done   = (state_q == S_DONE);
    assign Error  = (state_q == S_ERROR);
    assign HSIZE  = 3'(SHIFT);
    assign HBURST = 3'b000;
    assign HWDATA = d_q;
endmodule
